// File: rtl/fruit_pkg.sv
// Shared screen geometry and mover state type for the question-mark sprite motion controller.
package fruit_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPR_W    = 40;
  localparam int SPR_H    = 56;
  // Rightmost legal sprite origin; the glyph box must stay fully on screen.
  localparam int X_MAX    = SCREEN_W - SPR_W;

  typedef enum logic [1:0] {IDLE, DELAY, FLIGHT} mover_state_t;

  // Map a raw LFSR value onto the launch column range 40..551.
  function automatic logic [9:0] lfsr_launch_x(input logic [9:0] q);
    return {1'b0, q[8:0]} + 10'd40;
  endfunction

endpackage

// File: rtl/question_mover_lfsr10.sv
// 10-bit free-running Fibonacci LFSR (taps 10,7), seed 10'h001 on reset.
// Only built when QUESTION_LFSR_EN is defined; the default build has no LFSR logic.
`ifdef QUESTION_LFSR_EN
module lfsr10 (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] q
);

  logic [9:0] q_q, q_d;

  // Next value: shift left, feedback from bits 10 and 7 enters at the LSB
  always_comb begin
    q_d = {q_q[8:0], q_q[9] ^ q_q[6]};
  end

  // State register, steps every clock
  always_ff @(posedge clk) begin
    if (rst) q_q <= 10'h001;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule
`endif

// File: rtl/question_mover.sv
// Per-frame motion controller for the question-mark sprite: toss up from the bottom edge,
// decelerate under gravity, bounce off the side walls, end on hit or on exit at the bottom.
// Optional QUESTION_LFSR_EN: launch column taken from a free-running LFSR instead of LAUNCH_X.
module question_mover #(
  parameter int V0       = 14,
  parameter int GRAV_DIV = 2,
  parameter int VX       = 2,
  parameter int DELAY_FR = 60,
  parameter int LAUNCH_X = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       hit,
  output logic [9:0] x0,
  output logic [9:0] y0,
  output logic       en,
  output logic       busy,
  output logic       hit_ack,
  output logic       missed
);
  import fruit_pkg::*;

  localparam int FC_W = (DELAY_FR > 1) ? $clog2(DELAY_FR) : 1;
  localparam int GC_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam logic signed [10:0] Y_EXIT = 11'(SCREEN_H);
  localparam logic signed [10:0] X_LIM  = 11'(X_MAX);

  mover_state_t      state_q, state_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic [GC_W-1:0]   gc_q, gc_d;
  logic signed [7:0] vy_q, vy_d;
  logic signed [7:0] vx_q, vx_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic              hit_ack_q, hit_ack_d;
  logic              missed_q, missed_d;

  logic [9:0]         launch_x;
  logic signed [10:0] y_upd, x_upd;

`ifdef QUESTION_LFSR_EN
  logic [9:0] lfsr_val;

  lfsr10 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_val)
  );

  assign launch_x = lfsr_launch_x(lfsr_val);
`else
  assign launch_x = 10'(LAUNCH_X);
`endif

  // Candidate positions for this frame, in 11-bit signed so under/overflow is visible
  assign y_upd = $signed({1'b0, y_q}) - $signed({{3{vy_q[7]}}, vy_q});
  assign x_upd = $signed({1'b0, x_q}) + $signed({{3{vx_q[7]}}, vx_q});

  // Next-state and datapath update; everything holds unless a rule below fires
  always_comb begin
    state_d   = state_q;
    fc_d      = fc_q;
    gc_d      = gc_q;
    vy_d      = vy_q;
    vx_d      = vx_q;
    x_d       = x_q;
    y_d       = y_q;
    hit_ack_d = 1'b0;
    missed_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DELAY;
          fc_d    = '0;
        end
      end

      DELAY: begin
        if (frame_tick) begin
          if (fc_q == FC_W'(DELAY_FR - 1)) begin
            state_d = FLIGHT;
            x_d     = launch_x;
            y_d     = 10'(SCREEN_H);
            vy_d    = 8'(V0);
            gc_d    = '0;
            // Toss toward the far side of the screen
            vx_d    = (launch_x < 10'(SCREEN_W / 2)) ? 8'(VX) : -8'(VX);
          end else begin
            fc_d = fc_q + 1'b1;
          end
        end
      end

      FLIGHT: begin
        if (hit) begin
          // Slice takes priority over any motion or exit this cycle
          state_d   = IDLE;
          hit_ack_d = 1'b1;
        end else if (frame_tick) begin
          if (gc_q == GC_W'(GRAV_DIV - 1)) begin
            vy_d = vy_q - 8'sd1;
            gc_d = '0;
          end else begin
            gc_d = gc_q + 1'b1;
          end

          if (vy_q[7] && (y_upd >= Y_EXIT)) begin
            y_d      = 10'(SCREEN_H);
            missed_d = 1'b1;
            state_d  = IDLE;
          end else if (y_upd < 0) begin
            // Pinned at the top edge: stop rising, gravity restarts from rest
            y_d  = '0;
            vy_d = '0;
          end else begin
            y_d = y_upd[9:0];
          end

          if (x_upd > X_LIM) begin
            x_d  = 10'(X_MAX);
            vx_d = -vx_q;
          end else if (x_upd < 0) begin
            x_d  = '0;
            vx_d = -vx_q;
          end else begin
            x_d = x_upd[9:0];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      fc_q      <= '0;
      gc_q      <= '0;
      vy_q      <= '0;
      vx_q      <= '0;
      x_q       <= 10'(LAUNCH_X);
      y_q       <= 10'(SCREEN_H);
      hit_ack_q <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fc_q      <= fc_d;
      gc_q      <= gc_d;
      vy_q      <= vy_d;
      vx_q      <= vx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      hit_ack_q <= hit_ack_d;
      missed_q  <= missed_d;
    end
  end

  assign x0      = x_q;
  assign y0      = y_q;
  assign en      = (state_q == FLIGHT);
  assign busy    = (state_q != IDLE);
  assign hit_ack = hit_ack_q;
  assign missed  = missed_q;

endmodule
